// File: rtl/button_pkg.sv
// Shared types and constants for the button debouncer: channel FSM state,
// default timing parameters and the board's button index assignments.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } chan_state_e;

  // 10 ms of stable input at 25 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
  localparam int DEFAULT_SYNC_STAGES     = 2;

  localparam int BTN_FIRE  = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 2;
  localparam int BTN_START = 3;
  localparam int BTN_COIN  = 4;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: polarity fix-up, input synchronizer, stable-count FSM
// and registered level/press/release outputs.
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  chan_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;

  // Polarity is normalised before the chain so everything downstream sees 1 = pressed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i ^ ACTIVE_LOW};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // The first differing sample already counts as one, hence cnt=1 on entering a wait state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Debounces all front-panel/game buttons; one independent channel per pin,
// plus a combined any_press strobe for wake-up style consumers.
module button_debouncer
  import button_pkg::*;
#(
  parameter int N_BUTTONS       = 5,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release,
  output logic                 any_press
);

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_i     (btn_raw[i]),
      .level_o   (btn_level[i]),
      .press_o   (btn_press[i]),
      .release_o (btn_release[i])
    );
  end

  // Only combinational output; it is fed purely by registered pulses
  assign any_press = |btn_press;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: table vectors, hand-written corner sequences and
// random stimulus, all checked against a sliding-window reference model.
module tb_button_debouncer;
  import button_pkg::*;

  localparam int NB   = 3;
  localparam int DEB  = 4;
  localparam int SYNC = 2;

  logic           clk = 1'b0;
  logic           rstN = 1'b1;
  logic [NB-1:0]  btnRaw = '0;
  logic [NB-1:0]  btnRawAl = '1;
  logic [NB-1:0]  level0, press0, release0;
  logic [NB-1:0]  level1, press1, release1;
  logic           any0, any1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_debouncer #(
    .N_BUTTONS(NB), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rstN), .btn_raw(btnRaw), .btn_level(level0),
    .btn_press(press0), .btn_release(release0), .any_press(any0)
  );

  button_debouncer #(
    .N_BUTTONS(NB), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC), .ACTIVE_LOW(1'b1)
  ) dutAl (
    .clk(clk), .rst_n(rstN), .btn_raw(btnRawAl), .btn_level(level1),
    .btn_press(press1), .btn_release(release1), .any_press(any1)
  );

  // Model: a level flips once the last DEB synchronized samples all disagree with it
  logic [NB-1:0] sampHist[2][$];
  logic [NB-1:0] sHist[2][$];
  logic [NB-1:0] mLevel[2];
  logic [NB-1:0] mPress[2];
  logic [NB-1:0] mRelease[2];

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      sampHist[d].delete();
      sHist[d].delete();
      mLevel[d]   = '0;
      mPress[d]   = '0;
      mRelease[d] = '0;
    end
  endtask

  task automatic modelStep();
    logic [NB-1:0] pressed, s;
    bit allDiff;
    if (!rstN) begin
      modelReset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      pressed = (d == 0) ? btnRaw : ~btnRawAl;
      s = (sampHist[d].size() >= SYNC) ? sampHist[d][sampHist[d].size() - SYNC] : '0;
      sampHist[d].push_back(pressed);
      if (sampHist[d].size() > 8) void'(sampHist[d].pop_front());
      sHist[d].push_back(s);
      if (sHist[d].size() > DEB) void'(sHist[d].pop_front());
      mPress[d]   = '0;
      mRelease[d] = '0;
      if (sHist[d].size() == DEB) begin
        for (int c = 0; c < NB; c++) begin
          allDiff = 1'b1;
          for (int k = 0; k < DEB; k++)
            if (sHist[d][k][c] == mLevel[d][c]) allDiff = 1'b0;
          if (allDiff) begin
            mLevel[d][c] = ~mLevel[d][c];
            if (mLevel[d][c]) mPress[d][c] = 1'b1;
            else              mRelease[d][c] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("dut0 outputs", {22'd0, level0, press0, release0, any0},
               {22'd0, mLevel[0], mPress[0], mRelease[0], |mPress[0]});
    checkValue("dutAl outputs", {22'd0, level1, press1, release1, any1},
               {22'd0, mLevel[1], mPress[1], mRelease[1], |mPress[1]});
  endtask

  // One clock: drive at the falling edge, step the model at the rising edge, compare at the next fall
  task automatic applyStimulus(input logic [NB-1:0] raw, input logic [NB-1:0] rawAl);
    btnRaw   = raw;
    btnRawAl = rawAl;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  typedef struct {
    logic [NB-1:0] raw;
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] rel;
    logic          any;
  } vec_t;

  vec_t vecs[28];

  task automatic setVec(input int i, input logic [NB-1:0] raw, input logic [NB-1:0] lvl,
                        input logic [NB-1:0] prs, input logic [NB-1:0] rel, input logic any);
    vecs[i] = '{raw, lvl, prs, rel, any};
  endtask

  initial begin
    int firstEdge, pulseCnt;
    logic [NB-1:0] pulseSeen, r, ra;

    // Clean press on FIRE, release, then all three together
    for (int i = 0; i < 5; i++)   setVec(i, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0);
    setVec(5, 3'b001, 3'b001, 3'b001, 3'b000, 1'b1);
    setVec(6, 3'b001, 3'b001, 3'b000, 3'b000, 1'b0);
    for (int i = 7; i < 12; i++)  setVec(i, 3'b000, 3'b001, 3'b000, 3'b000, 1'b0);
    setVec(12, 3'b000, 3'b000, 3'b000, 3'b001, 1'b0);
    setVec(13, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    for (int i = 14; i < 19; i++) setVec(i, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0);
    setVec(19, 3'b111, 3'b111, 3'b111, 3'b000, 1'b1);
    setVec(20, 3'b111, 3'b111, 3'b000, 3'b000, 1'b0);
    for (int i = 21; i < 26; i++) setVec(i, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0);
    setVec(26, 3'b000, 3'b000, 3'b000, 3'b111, 1'b0);
    setVec(27, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

    modelReset();
    #1 rstN = 1'b0;
    #2;
    checkValue("reset dut0", {22'd0, level0, press0, release0, any0}, 32'd0);
    checkValue("reset dutAl", {22'd0, level1, press1, release1, any1}, 32'd0);
    @(negedge clk);
    // Button pressed while in reset must not leak through
    applyStimulus(3'b001, 3'b111);
    applyStimulus(3'b001, 3'b111);
    rstN = 1'b1;

    for (int i = 0; i < 28; i++) begin
      applyStimulus(vecs[i].raw, 3'b111);
      checkValue($sformatf("vec %0d", i), {22'd0, level0, press0, release0, any0},
                 {22'd0, vecs[i].level, vecs[i].press, vecs[i].rel, vecs[i].any});
    end

    // Bounce on LEFT: 2 high, 1 low, then steady high
    firstEdge = -1; pulseCnt = 0;
    for (int i = 0; i < 12; i++) begin
      r = (i == 2) ? 3'b000 : 3'b010;
      applyStimulus(r, 3'b111);
      if (press0[BTN_LEFT]) pulseCnt++;
      if (level0[BTN_LEFT] && firstEdge < 0) firstEdge = i;
    end
    checkValue("bounce level edge", firstEdge, 8);
    checkValue("bounce press count", pulseCnt, 1);
    for (int i = 0; i < 7; i++) applyStimulus(3'b000, 3'b111);

    // Release glitch on FIRE: 2 low, 1 high, then steady low
    for (int i = 0; i < 7; i++) applyStimulus(3'b001, 3'b111);
    checkValue("glitch held level", level0[BTN_FIRE], 1);
    firstEdge = -1; pulseCnt = 0;
    for (int i = 0; i < 12; i++) begin
      r = (i == 2) ? 3'b001 : 3'b000;
      applyStimulus(r, 3'b111);
      if (release0[BTN_FIRE]) pulseCnt++;
      if (!level0[BTN_FIRE] && firstEdge < 0) firstEdge = i;
    end
    checkValue("glitch release edge", firstEdge, 8);
    checkValue("glitch release count", pulseCnt, 1);

    // Reset while FIRE is mid-debounce and RIGHT is held
    for (int i = 0; i < 7; i++) applyStimulus(3'b100, 3'b111);
    for (int i = 0; i < 4; i++) applyStimulus(3'b101, 3'b111);
    #2 rstN = 1'b0;
    #1;
    checkValue("async reset dut0", {22'd0, level0, press0, release0, any0}, 32'd0);
    applyStimulus(3'b101, 3'b111);
    applyStimulus(3'b101, 3'b111);
    rstN = 1'b1;
    firstEdge = -1; pulseSeen = '0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'b101, 3'b111);
      if (level0 == 3'b101 && firstEdge < 0) begin
        firstEdge = i;
        pulseSeen = press0;
      end
    end
    checkValue("post-reset accept edge", firstEdge, 5);
    checkValue("post-reset press", pulseSeen, 3'b101);
    for (int i = 0; i < 7; i++) applyStimulus(3'b000, 3'b111);

    // Active-low instance: idle high, press FIRE by driving low
    for (int i = 0; i < 3; i++) applyStimulus(3'b000, 3'b111);
    firstEdge = -1; pulseSeen = '0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'b000, 3'b110);
      if (level1[BTN_FIRE] && firstEdge < 0) begin
        firstEdge = i;
        pulseSeen = press1;
      end
    end
    checkValue("active-low accept edge", firstEdge, 5);
    checkValue("active-low press", pulseSeen, 3'b001);
    for (int i = 0; i < 7; i++) applyStimulus(3'b000, 3'b111);

    // Random bursts with occasional toggles, one reset in the middle
    r = '0; ra = '1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3) == 0) r[$urandom_range(NB - 1)] ^= 1'b1;
      if ($urandom_range(3) == 0) ra[$urandom_range(NB - 1)] ^= 1'b1;
      if (i == 400) rstN = 1'b0;
      if (i == 403) rstN = 1'b1;
      applyStimulus(r, ra);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
